// File: rtl/counter_ctrl_8bit.sv
// Button front-end for sync_counter_8bit: synchronise, debounce, and sequence run/load control.
// Optional feature macro AUTO_STOP_EN: stop automatically when the counter reaches all ones.

module counter_ctrl_8bit_debounce #(
    parameter int unsigned DB_CYCLES = 4
) (
    input  logic clk,
    input  logic clr,
    input  logic btn,
    output logic press
);
    localparam int unsigned DCW = $clog2(DB_CYCLES + 1);

    logic           sync1;
    logic           sync2;
    logic           db;
    logic           db_q;
    logic [DCW-1:0] db_cnt;

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            db     <= 1'b0;
            db_q   <= 1'b0;
            db_cnt <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            db_q  <= db;
            // The count is "cycles of disagreement"; the level flips on the DB_CYCLES-th one.
            if (sync2 != db) begin
                if (db_cnt == DCW'(DB_CYCLES - 1)) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + DCW'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db & ~db_q;
endmodule

module counter_ctrl_8bit #(
    parameter int unsigned W         = 8,
    parameter int unsigned DB_CYCLES = 4,
    parameter int unsigned LOAD_HOLD = 1
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         btn_ss,
    input  logic         btn_ld,
    input  logic [W-1:0] sw,
    input  logic [W-1:0] c,
    output logic         s_s,
    output logic         l,
    output logic [W-1:0] d
);
    localparam int unsigned HCW = $clog2(LOAD_HOLD + 1);

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] RUN  = 2'b01;
    localparam logic [1:0] LOAD = 2'b10;

    logic           ss_press;
    logic           ld_press;
    logic [1:0]     state;
    logic [1:0]     state_nx;
    logic           ret;
    logic           ret_nx;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_nx;
    logic           capture;

    counter_ctrl_8bit_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_ss),
        .press (ss_press)
    );

    counter_ctrl_8bit_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ld (
        .clk   (clk),
        .clr   (clr),
        .btn   (btn_ld),
        .press (ld_press)
    );

`ifdef AUTO_STOP_EN
    logic at_max;
    assign at_max = (c == '1);
`else
    logic unused_c;
    assign unused_c = ^c;
`endif

    always_comb begin
        state_nx = state;
        ret_nx   = ret;
        hold_nx  = hold_cnt;
        capture  = 1'b0;
        case (state)
            IDLE: begin
                if (ld_press) begin
                    state_nx = LOAD;
                    ret_nx   = 1'b0;
                    hold_nx  = '0;
                    capture  = 1'b1;
                end else if (ss_press) begin
                    state_nx = RUN;
                end
            end
            RUN: begin
                if (ld_press) begin
                    state_nx = LOAD;
                    ret_nx   = 1'b1;
                    hold_nx  = '0;
                    capture  = 1'b1;
`ifdef AUTO_STOP_EN
                end else if (at_max) begin
                    state_nx = IDLE;
`endif
                end else if (ss_press) begin
                    state_nx = IDLE;
                end
            end
            LOAD: begin
                // Presses arriving here are dropped, not queued.
                if (hold_cnt == HCW'(LOAD_HOLD - 1)) begin
                    state_nx = ret ? RUN : IDLE;
                end else begin
                    hold_nx = hold_cnt + HCW'(1);
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet aligned with it.
    always_ff @(posedge clk) begin
        if (!clr) begin
            state    <= IDLE;
            ret      <= 1'b0;
            hold_cnt <= '0;
            s_s      <= 1'b0;
            l        <= 1'b0;
            d        <= '0;
        end else begin
            state    <= state_nx;
            ret      <= ret_nx;
            hold_cnt <= hold_nx;
            s_s      <= (state_nx == RUN);
            l        <= (state_nx == LOAD);
            if (capture) begin
                d <= sw;
            end
        end
    end
endmodule
